parking_slot_manager: RTL
=========================

# parking_slot_manager

Central slot allocator for a multi-gate car park. Each entry gate's controller raises a request once its driver's password is accepted. This block round-robins between gates and allocates the lowest-numbered free bay, or denies the request when the lot is full. It also releases bays reported by exit gates and publishes occupancy to the display and signage logic.

## Interface
Parameters:
- NUM_GATES, 2: number of entry gates, 2..8.
- NUM_SLOTS, 8: number of bays, 2..64.
- SLOT_W, $clog2(NUM_SLOTS): width of a bay index. Derived; never overridden.

Ports:
- clock  in  1  system clock; all logic is rising-edge.
- reset  in  1  asynchronous, active-high; returns every register to its reset value.
- entry_req  in  NUM_GATES  per-gate level request. Held high until that gate sees its grant or deny, then dropped.
- entry_grant  out  NUM_GATES  one-hot, one-cycle pulse: the bay is allocated to that gate.
- entry_deny  out  NUM_GATES  one-hot, one-cycle pulse: the lot is full.
- slot_id  out  SLOT_W  allocated bay index; valid only while entry_grant is nonzero.
- exit_valid  in  1  one-cycle pulse: a car has left bay exit_slot.
- exit_slot  in  SLOT_W  bay being released; sampled only when exit_valid=1.
- exit_err  out  1  one-cycle pulse: release of a bay that is already free, or exit_slot >= NUM_SLOTS.
- slot_map  out  NUM_SLOTS  registered occupancy bitmap; 1 = occupied.
- occupancy  out  SLOT_W+1  registered count of occupied bays.
- full  out  1  occupancy == NUM_SLOTS.
- empty  out  1  occupancy == 0.

## Operation
- Reset values: all outputs 0 except empty=1. Internal state: state=IDLE, rr_ptr=0.
- FSM states: IDLE, SERVE, WAIT_DROP.
- IDLE: if any entry_req bit is set, latch the round-robin winner (search starts at rr_ptr) into gate_sel, then go to SERVE.
- SERVE, one cycle:
  - If full=0: pulse entry_grant[gate_sel], drive slot_id = lowest-index 0 bit of slot_map, set that bit, increment occupancy.
  - If full=1: pulse entry_deny[gate_sel]; no state change.
  - rr_ptr <= gate_sel+1 (mod NUM_GATES).
  - Go to WAIT_DROP.
- WAIT_DROP: stay until entry_req[gate_sel]=0, then go to IDLE. This prevents a held request from being served twice.
- Exit handling is independent of the FSM and accepted in every state:
  - Valid release (in range and bit set): clear the bit and decrement occupancy.
  - Invalid release: pulse exit_err; slot_map and occupancy unchanged.
- Grant and release in the same cycle:
  - Both bitmap updates apply.
  - Occupancy is unchanged (+1-1).
  - The full/deny decision uses the registered full value from the start of the cycle. A bay freed in that cycle is not offered until the next request.
- Occupancy arithmetic is SLOT_W+1 bits wide. It cannot wrap: a grant happens only when full=0, and a decrement happens only on a set bit.
- full and empty are combinational from registered occupancy.

## Timing
- Request to response: a request seen high in cycle N (state IDLE) gives grant/deny in cycle N+1.
- slot_map and occupancy update on the edge that ends the grant cycle, so they show the new value in cycle N+2.
- Release: exit_valid in cycle M gives updated slot_map/occupancy in cycle M+1. exit_err pulses in cycle M+1.
- Throughput: minimum 3 cycles per request, because the FSM cannot return to IDLE until entry_req drops.
- Reset asserted mid-transaction: any pending grant is aborted, the bitmap is cleared and rr_ptr returns to 0. Gates must re-request after reset.

## Structure
- Shared package parking_pkg holds:
  - the slot_mgr_state_t enum (IDLE, SERVE, WAIT_DROP);
  - localparams for the default NUM_GATES and NUM_SLOTS.
- The existing gate-controller state encodings move into the same package.
- Sub-module rr_arbiter (parameter N) takes req[N] and ptr, and returns a one-hot winner plus its index. It is reused by future shared-resource blocks.
- The lowest-free-bay priority encoder stays inline.

## Test plan
- Reset, then entry_req=2'b01 → entry_grant=01 with slot_id=0 one cycle later; occupancy=1, slot_map=8'h01, empty=0.
- entry_req=2'b11 held, each gate dropping its request after being served → gate0 granted bay 0, then gate1 granted bay 1; rr_ptr alternates; no gate is served twice.
- Fill all 8 bays, then request from gate1 → entry_deny=10; full=1 and occupancy=8 unchanged.
- exit_valid with exit_slot=3 in the same cycle as a grant at occupancy=5 → bay 3 cleared, new bay set, occupancy stays 5.
- Release bay 6 while it is free, and separately exit_slot=7 at NUM_SLOTS=6 → exit_err pulses once per event; map unchanged.
- Assert reset while in SERVE with occupancy=4 → all outputs return to reset values immediately; no grant pulse is emitted.

Source files
------------

// File: rtl/parking_pkg.sv
// Shared types for the car-park control blocks: slot manager FSM, gate controller FSM, default sizes.
package parking_pkg;

    localparam int unsigned DEF_NUM_GATES = 2;
    localparam int unsigned DEF_NUM_SLOTS = 8;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        SERVE     = 2'd1,
        WAIT_DROP = 2'd2
    } slot_mgr_state_t;

    typedef enum logic [2:0] {
        GC_IDLE      = 3'd0,
        GC_PW_ENTRY  = 3'd1,
        GC_PW_CHECK  = 3'd2,
        GC_WAIT_SLOT = 3'd3,
        GC_GATE_OPEN = 3'd4,
        GC_LOCKOUT   = 3'd5
    } gate_ctrl_state_t;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: first set request at or after i_ptr wins (wrapping).
module rr_arbiter #(
    parameter  int unsigned N  = 2,
    localparam int unsigned IW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  i_req,
    input  logic [IW-1:0] i_ptr,
    output logic [N-1:0]  o_grant_c,
    output logic [IW-1:0] o_idx_c
);

    logic        w_found;
    int unsigned w_cand;

    always_comb begin
        o_grant_c = '0;
        o_idx_c   = '0;
        w_found   = 1'b0;
        w_cand    = 0;
        for (int unsigned k = 0; k < N; k++) begin
            w_cand = (32'(i_ptr) + k) % N;
            if (!w_found && i_req[IW'(w_cand)]) begin
                w_found                = 1'b1;
                o_idx_c                = IW'(w_cand);
                o_grant_c[IW'(w_cand)] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/parking_slot_manager.sv
// Central bay allocator: round-robins entry gates, grants the lowest free bay or denies when full,
// releases bays from exit gates and tracks occupancy.
module parking_slot_manager
    import parking_pkg::*;
#(
    parameter int unsigned NUM_GATES = DEF_NUM_GATES,
    parameter int unsigned NUM_SLOTS = DEF_NUM_SLOTS,
    parameter int unsigned SLOT_W    = $clog2(NUM_SLOTS)
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic [NUM_GATES-1:0] entry_req,
    output logic [NUM_GATES-1:0] entry_grant,
    output logic [NUM_GATES-1:0] entry_deny,
    output logic [SLOT_W-1:0]    slot_id,
    input  logic                 exit_valid,
    input  logic [SLOT_W-1:0]    exit_slot,
    output logic                 exit_err,
    output logic [NUM_SLOTS-1:0] slot_map,
    output logic [SLOT_W:0]      occupancy,
    output logic                 full,
    output logic                 empty
);

    localparam int unsigned GATE_W = $clog2(NUM_GATES);
    localparam int unsigned OCC_W  = SLOT_W + 1;
    localparam int unsigned PAD_W  = 1 << SLOT_W;

    slot_mgr_state_t      r_state;
    slot_mgr_state_t      w_state_nx;
    logic [GATE_W-1:0]    r_gate_sel;
    logic [GATE_W-1:0]    w_gate_sel_nx;
    logic [GATE_W-1:0]    r_rr_ptr;
    logic [GATE_W-1:0]    w_rr_ptr_nx;
    logic [NUM_SLOTS-1:0] r_slot_map;
    logic [NUM_SLOTS-1:0] w_slot_map_nx;
    logic [OCC_W-1:0]     r_occupancy;
    logic [OCC_W-1:0]     w_occupancy_nx;
    logic                 r_exit_err;

    logic [NUM_GATES-1:0] w_arb_grant;
    logic [GATE_W-1:0]    w_arb_idx;
    logic [SLOT_W-1:0]    w_free_idx;
    logic [PAD_W-1:0]     w_clr_pad;
    logic [NUM_SLOTS-1:0] w_clr_mask;
    logic [NUM_SLOTS-1:0] w_set_mask;
    logic                 w_full;
    logic                 w_grant_fire;
    logic                 w_deny_fire;
    logic                 w_exit_ok;

    rr_arbiter #(
        .N (NUM_GATES)
    ) u_rr_arbiter (
        .i_req     (entry_req),
        .i_ptr     (r_rr_ptr),
        .o_grant_c (w_arb_grant),
        .o_idx_c   (w_arb_idx)
    );

    // Lowest-index free bay; only meaningful while the lot is not full.
    always_comb begin
        w_free_idx = '0;
        for (int i = int'(NUM_SLOTS) - 1; i >= 0; i--) begin
            if (!r_slot_map[i]) begin
                w_free_idx = SLOT_W'(i);
            end
        end
    end

    // Out-of-range exit_slot shifts past the bitmap, so it never matches an occupied bay.
    assign w_clr_pad    = PAD_W'(1) << exit_slot;
    assign w_clr_mask   = w_clr_pad[NUM_SLOTS-1:0];
    assign w_set_mask   = NUM_SLOTS'(1) << w_free_idx;
    assign w_exit_ok    = exit_valid && ((w_clr_mask & r_slot_map) != '0);

    assign w_full       = (r_occupancy == OCC_W'(NUM_SLOTS));
    assign w_grant_fire = (r_state == SERVE) && !w_full;
    assign w_deny_fire  = (r_state == SERVE) && w_full;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state    <= IDLE;
            r_gate_sel <= '0;
            r_rr_ptr   <= '0;
        end else begin
            r_state    <= w_state_nx;
            r_gate_sel <= w_gate_sel_nx;
            r_rr_ptr   <= w_rr_ptr_nx;
        end
    end

    always_comb begin
        w_state_nx    = r_state;
        w_gate_sel_nx = r_gate_sel;
        w_rr_ptr_nx   = r_rr_ptr;
        case (r_state)
            IDLE: begin
                if (w_arb_grant != '0) begin
                    w_gate_sel_nx = w_arb_idx;
                    w_state_nx    = SERVE;
                end
            end
            SERVE: begin
                w_rr_ptr_nx = (r_gate_sel == GATE_W'(NUM_GATES - 1)) ? '0 : r_gate_sel + GATE_W'(1);
                w_state_nx  = WAIT_DROP;
            end
            WAIT_DROP: begin
                // Hold off until the served gate drops its request so it is not served twice.
                if (!entry_req[r_gate_sel]) begin
                    w_state_nx = IDLE;
                end
            end
            default: w_state_nx = IDLE;
        endcase
    end

    // Grant and release in one cycle touch different bays and cancel in the count.
    always_comb begin
        w_slot_map_nx  = r_slot_map;
        w_occupancy_nx = r_occupancy;
        if (w_grant_fire) begin
            w_slot_map_nx = w_slot_map_nx | w_set_mask;
        end
        if (w_exit_ok) begin
            w_slot_map_nx = w_slot_map_nx & ~w_clr_mask;
        end
        if (w_grant_fire && !w_exit_ok) begin
            w_occupancy_nx = r_occupancy + OCC_W'(1);
        end else if (w_exit_ok && !w_grant_fire) begin
            w_occupancy_nx = r_occupancy - OCC_W'(1);
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_slot_map  <= '0;
            r_occupancy <= '0;
            r_exit_err  <= 1'b0;
        end else begin
            r_slot_map  <= w_slot_map_nx;
            r_occupancy <= w_occupancy_nx;
            r_exit_err  <= exit_valid && !w_exit_ok;
        end
    end

    assign entry_grant = w_grant_fire ? (NUM_GATES'(1) << r_gate_sel) : '0;
    assign entry_deny  = w_deny_fire  ? (NUM_GATES'(1) << r_gate_sel) : '0;
    assign slot_id     = w_grant_fire ? w_free_idx : '0;
    assign exit_err    = r_exit_err;
    assign slot_map    = r_slot_map;
    assign occupancy   = r_occupancy;
    assign full        = w_full;
    assign empty       = (r_occupancy == '0);

endmodule
